// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled from the baud tick strobe
//
// Purpose:
//   Deserialises an asynchronous serial line into parallel bytes. The line is
//   first synchronised, then a four-state FSM (IDLE/START/DATA/STOP) counts
//   oversampling ticks to sample each bit near its centre.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_rx            asynchronous serial line, idles high
//   i_tick          one-clk strobe at 16x the baud rate
//   o_dout          last received byte, held until the next frame completes
//   o_rx_done_tick  one-clk pulse when a frame completes
//   o_frame_err     stop bit was sampled low on the last completed frame

module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [3:0]    S_MID_START = 4'd7;
  localparam logic [3:0]    S_BIT_LAST  = 4'd15;
  localparam logic [3:0]    S_STOP_LAST = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Two-flop synchroniser; resets to the idle (high) line level so that a
  // reset never looks like a start bit.
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  state_t          r_state, w_state_next;
  logic [3:0]      r_s,     w_s_next;
  logic [NW-1:0]   r_n,     w_n_next;
  logic [DBIT-1:0] r_b,     w_b_next;
  logic [DBIT-1:0] r_dout,  w_dout_next;
  logic            r_done,  w_done_next;
  logic            r_ferr,  w_ferr_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_dout  <= w_dout_next;
      r_done  <= w_done_next;
      r_ferr  <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_dout_next  = r_dout;
    w_done_next  = 1'b0;
    w_ferr_next  = r_ferr;

    case (r_state)
      // Start detection runs every clk, not only on ticks, to keep the
      // detection jitter to the synchroniser plus one clk.
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = ST_START;
          w_s_next     = '0;
        end
      end

      // Re-check the line in the middle of the start bit; a high line here
      // means the falling edge was a glitch and nothing is reported.
      ST_START: begin
        if (i_tick) begin
          if (r_s == S_MID_START) begin
            if (!w_rx_s) begin
              w_state_next = ST_DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end

      // From mid start bit, every 16 ticks lands on the middle of the next
      // data bit. Bits arrive LSB first, so shift in from the top.
      ST_DATA: begin
        if (i_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next = '0;
            w_b_next = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
              w_state_next = ST_STOP;
            end else begin
              w_n_next = r_n + NW'(1);
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end

      // A low stop bit still delivers the byte, flagged as a framing error.
      ST_STOP: begin
        if (i_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_state_next = ST_IDLE;
            w_dout_next  = r_b;
            w_ferr_next  = ~w_rx_s;
            w_done_next  = 1'b1;
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_dout         = r_dout;
  assign o_rx_done_tick = r_done;
  assign o_frame_err    = r_ferr;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous 8N1 line into parallel bytes. It sits directly downstream of the baud-rate generator and consumes its one-clock `tick` strobe, which runs at 16× the baud rate, to oversample `rx`. Each completed frame produces a byte on `dout` with a one-cycle `rx_done_tick` and a framing-error flag, for use by the UART interface/FIFO stage.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: ticks spent sampling the stop bit (16 gives 1 stop bit).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `tick`  in  1  one-`clk`-wide strobe at 16× baud, from the baud-rate generator.
- `dout`  out  DBIT  last received byte; held until the next frame completes.
- `rx_done_tick`  out  1  one-cycle pulse when a frame completes.
- `frame_err`  out  1  stop bit sampled low on the last completed frame; updated with `rx_done_tick`.

## Operation
- `rx` passes through a 2-flop synchroniser to `rx_s`, reset value 1. All decisions use `rx_s`.
- Registers:
  - `state`: IDLE, START, DATA or STOP.
  - `s`: 4-bit tick counter.
  - `n`: log2(DBIT)-bit bit counter.
  - `b`: DBIT-bit shift register.
- IDLE: `rx_s==0` → START with `s=0`. This is evaluated every clk and does not wait for `tick`.
- START, on `tick`:
  - `s==7`, mid start bit: if `rx_s==0` → DATA with `s=0`, `n=0`. If `rx_s==1` the start was a glitch → IDLE, and no outputs change.
  - Otherwise `s++`.
- DATA, on `tick`:
  - `s==15`: `s=0` and `b={rx_s, b[DBIT-1:1]}`, shifting in LSB first. If `n==DBIT-1` → STOP, else `n++`.
  - Otherwise `s++`.
- STOP, on `tick`:
  - `s==SB_TICK-1`: → IDLE, `dout<=b`, `frame_err<=~rx_s`, `rx_done_tick<=1`.
  - Otherwise `s++`.
- With no `tick`, counters and state hold. The only exception is IDLE→START.
- `rx_done_tick` is 0 in every cycle except the pulse cycle.
- A framing error still delivers `b` on `dout`, with `frame_err=1`.
- Reset, at any time including mid-frame:
  - state → IDLE; `s`, `n`, `b` → 0.
  - `dout` → 0, `rx_done_tick` → 0, `frame_err` → 0.
  - Synchroniser flops → 1.
  - Any partial frame is discarded.
- Once back in IDLE, a line low at that time starts a new frame immediately. Back-to-back frames need no extra idle time.

## Timing
- Synchroniser latency: 2 clk from `rx` to `rx_s`.
- Start detection: up to 2 clk after the falling edge plus synchroniser delay.
- Sampling points: data bit k is sampled at the tick ending 8+16(k+1) ticks after START entry. This is near mid-bit, with ±1-tick detection jitter.
- `rx_done_tick` and the `dout`/`frame_err` updates appear on the clk edge that consumes the final stop tick. The pulse lasts exactly 1 clk.
- Frame-to-done latency: about (7+1) + 16·DBIT + SB_TICK ticks after START entry, i.e. 152 ticks for the defaults.
- Outputs are registered, with no combinational path from inputs.

## Test plan
Benches drive `tick` for 1 clk every 4 clk, giving 64 clk per bit. `rx` is driven by a bit-accurate serialiser.
- Reset held 10 clk, then `rx=1` for 200 clk → `dout=0x00`, `rx_done_tick=0`, `frame_err=0` throughout.
- Frame 0x55, then frame 0xA3 back-to-back with 1 stop bit each → exactly two `rx_done_tick` pulses, each 1 clk wide. `dout=0x55` then `0xA3`; `frame_err=0` both times.
- Glitch: `rx` low for 3 ticks (12 clk), then high → no `rx_done_tick`; the FSM returns to IDLE; a following 0x3C frame is received correctly.
- Framing error: frame 0x81 with the stop bit driven 0 → `rx_done_tick` pulses, `dout=0x81`, `frame_err=1`. The next clean frame 0x7E clears it: `frame_err=0`.
- Reset mid-frame, asserted for 1 clk during data bit 4 → no pulse for that frame, outputs reset to 0. A subsequent full frame 0x0F gives `dout=0x0F` and one pulse.
- Tick gating: hold `tick=0` for 500 clk mid-DATA, then resume → the frame still decodes correctly, since counters freeze without `tick`.
